// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit: forwarding select codes,
// multiplier-tracker state codes and the register-match rule.
package hazard_unit_pkg;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M_ALU   = 2'b10;
    localparam logic [1:0] FWD_M_HILO  = 2'b11;

    typedef enum logic {
        TRK_IDLE = 1'b0,
        TRK_BUSY = 1'b1
    } trk_state_e;

    // Register $0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Control-unit <-> hazard-unit bundle. master = control/pipeline side, slave = hazard unit.
// Handshake: none; every signal is a level that is valid for the whole cycle it is presented in.
interface hazard_unit_if
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = 32
) ();
    logic [4:0]       rsD, rtD, rsE, rtE;
    logic [4:0]       rf_waE, rf_waM, rf_waW;
    logic             we_regE, we_regM, we_regW;
    logic             dm2regE, dm2regM, sf2regM;
    logic             branchD, jrD, sf2regD;
    logic             mult_enableD, mult_enableE;

    logic             StallF, StallD, FlushE;
    logic             ForwardAD, ForwardBD;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             mult_busy;
    logic [CNT_W-1:0] stall_cycles;
    trk_state_e       trk_state;

    modport master (
        output rsD, rtD, rsE, rtE, rf_waE, rf_waM, rf_waW,
               we_regE, we_regM, we_regW, dm2regE, dm2regM, sf2regM,
               branchD, jrD, sf2regD, mult_enableD, mult_enableE,
        input  StallF, StallD, FlushE, ForwardAD, ForwardBD,
               ForwardAE, ForwardBE, mult_busy, stall_cycles, trk_state
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, rf_waE, rf_waM, rf_waW,
               we_regE, we_regM, we_regW, dm2regE, dm2regM, sf2regM,
               branchD, jrD, sf2regD, mult_enableD, mult_enableE,
        output StallF, StallD, FlushE, ForwardAD, ForwardBD,
               ForwardAE, ForwardBE, mult_busy, stall_cycles, trk_state
    );
endinterface

// File: rtl/hazard_mult_tracker.sv
// Tracks an in-flight multi-cycle multiply: busy from the cycle after mult
// leaves E until HI/LO are valid (MULT_LAT cycles in total).
module hazard_mult_tracker
    import hazard_unit_pkg::*;
#(
    parameter int MULT_LAT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_mult_enable,
    output logic       o_busy,
    output trk_state_e o_state
);
    localparam int       CW     = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam bit       LAT_EN = (MULT_LAT > 0);
    localparam logic [CW-1:0] LOAD = (MULT_LAT > 0) ? CW'(MULT_LAT - 1) : '0;

    trk_state_e    r_state;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= TRK_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                TRK_IDLE: begin
                    if (i_mult_enable && LAT_EN) begin
                        r_state <= TRK_BUSY;
                        r_cnt   <= LOAD;
                    end
                end
                TRK_BUSY: begin
                    // A new mult here should have been stalled; restart the count anyway.
                    if (i_mult_enable) begin
                        r_cnt <= LOAD;
                    end else if (r_cnt == '0) begin
                        r_state <= TRK_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= TRK_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_busy  = (r_state == TRK_BUSY);
    assign o_state = r_state;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use/branch/multiply stalls,
// and a saturating count of stalled cycles.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_unit_if.slave  hz
);
    localparam bit LAT_EN = (MULT_LAT > 0);

    logic             w_mult_busy;
    logic             w_mult_pend;
    logic             w_lw_stall;
    logic             w_br_stall;
    logic             w_md_stall;
    logic             w_stall;
    logic             w_rs_dep;
    logic             w_rt_dep;
    logic [CNT_W-1:0] r_stall_cycles;

    // M-stage match wins over W so the youngest producer is forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] wa_m,
                                           input logic [4:0] wa_w, input logic we_m,
                                           input logic we_w, input logic sf_m);
        if (we_m && reg_match(src, wa_m)) return sf_m ? FWD_M_HILO : FWD_M_ALU;
        if (we_w && reg_match(src, wa_w)) return FWD_W;
        return FWD_RF;
    endfunction

    assign hz.ForwardAE = fwd_sel(hz.rsE, hz.rf_waM, hz.rf_waW, hz.we_regM, hz.we_regW, hz.sf2regM);
    assign hz.ForwardBE = fwd_sel(hz.rtE, hz.rf_waM, hz.rf_waW, hz.we_regM, hz.we_regW, hz.sf2regM);

    assign hz.ForwardAD = hz.we_regM && reg_match(hz.rsD, hz.rf_waM) && !hz.dm2regM && !hz.sf2regM;
    assign hz.ForwardBD = hz.we_regM && reg_match(hz.rtD, hz.rf_waM) && !hz.dm2regM && !hz.sf2regM;

    assign w_lw_stall = hz.dm2regE && hz.we_regE &&
                        (reg_match(hz.rsD, hz.rf_waE) || reg_match(hz.rtD, hz.rf_waE));

    // D-stage compares need the operand now: producer still in E, or in M but not from the ALU.
    assign w_rs_dep = (hz.we_regE && reg_match(hz.rsD, hz.rf_waE)) ||
                      ((hz.dm2regM || hz.sf2regM) && reg_match(hz.rsD, hz.rf_waM));
    assign w_rt_dep = (hz.we_regE && reg_match(hz.rtD, hz.rf_waE)) ||
                      ((hz.dm2regM || hz.sf2regM) && reg_match(hz.rtD, hz.rf_waM));
    assign w_br_stall = (hz.branchD && (w_rs_dep || w_rt_dep)) || (hz.jrD && w_rs_dep);

    assign w_mult_pend = w_mult_busy || (hz.mult_enableE && LAT_EN);
    assign w_md_stall  = w_mult_pend && (hz.sf2regD || hz.mult_enableD);

    assign w_stall   = w_lw_stall | w_br_stall | w_md_stall;
    assign hz.StallF = w_stall;
    assign hz.StallD = w_stall;
    assign hz.FlushE = w_stall;

    hazard_mult_tracker #(.MULT_LAT(MULT_LAT)) u_mult_tracker (
        .i_clk         (clk),
        .i_rst_n       (rst),
        .i_mult_enable (hz.mult_enableE),
        .o_busy        (w_mult_busy),
        .o_state       (hz.trk_state)
    );
    assign hz.mult_busy = w_mult_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end
    assign hz.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (MULT_LAT=4/CNT_W=32 and MULT_LAT=0/CNT_W=4)
// driven with identical stimulus and compared against a rule-level model.
module tb_hazard_unit;

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, waE, waM, waW;
    logic weE, weM, weW, dmE, dmM, sfM, br, jr, sfD, meD, meE;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(32)) bus_a ();
  hazard_unit_if #(.CNT_W(4))  bus_b ();

  hazard_unit #(.MULT_LAT(4), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .hz(bus_a));
  hazard_unit #(.MULT_LAT(0), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .hz(bus_b));

  int n_checks = 0;
  int n_err = 0;
  stim_t cur;
  int rem_a;            // cycles until the LAT=4 multiply result is valid
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

  function automatic logic [1:0] e_fwd(input logic [4:0] src, input stim_t s);
    if (s.weM && hit(src, s.waM)) return s.sfM ? 2'b11 : 2'b10;
    if (s.weW && hit(src, s.waW)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit e_fd(input logic [4:0] src, input stim_t s);
    return s.weM && hit(src, s.waM) && !s.dmM && !s.sfM;
  endfunction

  function automatic bit e_dep(input logic [4:0] src, input stim_t s);
    return (s.weE && hit(src, s.waE)) || ((s.dmM || s.sfM) && hit(src, s.waM));
  endfunction

  function automatic bit e_stall(input stim_t s, input bit pend);
    bit lw, br, md;
    lw = s.dmE && s.weE && (hit(s.rsD, s.waE) || hit(s.rtD, s.waE));
    br = (s.br && (e_dep(s.rsD, s) || e_dep(s.rtD, s))) || (s.jr && e_dep(s.rsD, s));
    md = pend && (s.sfD || s.meD);
    return lw || br || md;
  endfunction

  function automatic stim_t zero_stim();
    stim_t s;
    s.rsD = 0; s.rtD = 0; s.rsE = 0; s.rtE = 0; s.waE = 0; s.waM = 0; s.waW = 0;
    s.weE = 0; s.weM = 0; s.weW = 0; s.dmE = 0; s.dmM = 0; s.sfM = 0;
    s.br = 0; s.jr = 0; s.sfD = 0; s.meD = 0; s.meE = 0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    cur = s;
    bus_a.rsD = s.rsD; bus_a.rtD = s.rtD; bus_a.rsE = s.rsE; bus_a.rtE = s.rtE;
    bus_a.rf_waE = s.waE; bus_a.rf_waM = s.waM; bus_a.rf_waW = s.waW;
    bus_a.we_regE = s.weE; bus_a.we_regM = s.weM; bus_a.we_regW = s.weW;
    bus_a.dm2regE = s.dmE; bus_a.dm2regM = s.dmM; bus_a.sf2regM = s.sfM;
    bus_a.branchD = s.br; bus_a.jrD = s.jr; bus_a.sf2regD = s.sfD;
    bus_a.mult_enableD = s.meD; bus_a.mult_enableE = s.meE;
    bus_b.rsD = s.rsD; bus_b.rtD = s.rtD; bus_b.rsE = s.rsE; bus_b.rtE = s.rtE;
    bus_b.rf_waE = s.waE; bus_b.rf_waM = s.waM; bus_b.rf_waW = s.waW;
    bus_b.we_regE = s.weE; bus_b.we_regM = s.weM; bus_b.we_regW = s.weW;
    bus_b.dm2regE = s.dmE; bus_b.dm2regM = s.dmM; bus_b.sf2regM = s.sfM;
    bus_b.branchD = s.br; bus_b.jrD = s.jr; bus_b.sf2regD = s.sfD;
    bus_b.mult_enableD = s.meD; bus_b.mult_enableE = s.meE;
  endtask

  task automatic check_all();
    bit sa, sb;
    sa = e_stall(cur, (rem_a > 0) || cur.meE);
    sb = e_stall(cur, 1'b0);
    check_eq("a_StallF", bus_a.StallF, sa);
    check_eq("a_StallD", bus_a.StallD, sa);
    check_eq("a_FlushE", bus_a.FlushE, sa);
    check_eq("a_FwdAE", bus_a.ForwardAE, e_fwd(cur.rsE, cur));
    check_eq("a_FwdBE", bus_a.ForwardBE, e_fwd(cur.rtE, cur));
    check_eq("a_FwdAD", bus_a.ForwardAD, e_fd(cur.rsD, cur));
    check_eq("a_FwdBD", bus_a.ForwardBD, e_fd(cur.rtD, cur));
    check_eq("a_busy", bus_a.mult_busy, rem_a > 0);
    check_eq("a_cycles", bus_a.stall_cycles, cnt_a);
    check_eq("b_StallF", bus_b.StallF, sb);
    check_eq("b_FlushE", bus_b.FlushE, sb);
    check_eq("b_FwdBE", bus_b.ForwardBE, e_fwd(cur.rtE, cur));
    check_eq("b_FwdBD", bus_b.ForwardBD, e_fd(cur.rtD, cur));
    check_eq("b_busy", bus_b.mult_busy, 1'b0);
    check_eq("b_cycles", bus_b.stall_cycles, cnt_b);
  endtask

  // Advance one clock edge and move the model to match.
  task automatic tick();
    bit sa, sb;
    sa = e_stall(cur, (rem_a > 0) || cur.meE);
    sb = e_stall(cur, 1'b0);
    @(posedge clk);
    if (sa && cnt_a != 32'hFFFF_FFFF) cnt_a++;
    if (sb && cnt_b != 4'hF) cnt_b++;
    if (cur.meE) rem_a = 4;
    else if (rem_a > 0) rem_a--;
    #1;
  endtask

  task automatic cycle(input stim_t s);
    drive(s);
    #2;
    check_all();
    tick();
  endtask

  initial begin
    stim_t s;
    int busy_n;
    rst = 1'b0;
    rem_a = 0; cnt_a = '0; cnt_b = '0;
    drive(zero_stim());
    #2;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(zero_stim());

    // Forwarding priority and $0 exclusion
    s = zero_stim();
    s.rsE = 5; s.waM = 5; s.weM = 1; s.waW = 5; s.weW = 1;
    drive(s); #2; check_eq("fwd_m_alu", bus_a.ForwardAE, 2'b10); check_all(); tick();
    s.sfM = 1;
    drive(s); #2; check_eq("fwd_m_hilo", bus_a.ForwardAE, 2'b11); check_all(); tick();
    s.weM = 0;
    drive(s); #2; check_eq("fwd_w", bus_a.ForwardAE, 2'b01); check_all(); tick();
    s.weM = 1; s.rsE = 0;
    drive(s); #2; check_eq("fwd_r0", bus_a.ForwardAE, 2'b00); check_all(); tick();

    // Load-use: one stalled cycle, counter steps by one
    s = zero_stim();
    s.dmE = 1; s.weE = 1; s.waE = 8; s.rtD = 8;
    drive(s); #2; check_eq("lw_stall", bus_a.StallF, 1'b1); check_all(); tick();
    drive(zero_stim()); #2; check_eq("lw_count", bus_a.stall_cycles, 32'd1); check_all(); tick();

    // Branch: stalls on E producer, then forwards from M ALU
    s = zero_stim();
    s.br = 1; s.rsD = 9; s.waE = 9; s.weE = 1;
    drive(s); #2; check_eq("br_stall", bus_a.StallD, 1'b1); check_all(); tick();
    s.weE = 0; s.waE = 0; s.waM = 9; s.weM = 1;
    drive(s); #2; check_eq("br_nostall", bus_a.StallD, 1'b0);
    check_eq("br_fwdAD", bus_a.ForwardAD, 1'b1); check_all(); tick();

    // Multiply with mfhi waiting in D
    s = zero_stim();
    s.meE = 1; s.sfD = 1;
    drive(s); #2; check_eq("md_launch", bus_a.StallF, 1'b1);
    check_eq("md_lat0", bus_b.StallF, 1'b0); check_all(); tick();
    s.meE = 0;
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      drive(s); #2; check_all();
      if (!bus_a.mult_busy) break;
      busy_n++;
      tick();
    end
    check_eq("md_busy_len", busy_n, 4);
    check_eq("md_release", bus_a.StallF, 1'b0);
    tick();

    // Asynchronous reset in the middle of a multiply
    s = zero_stim(); s.meE = 1;
    cycle(s);
    s.meE = 0; s.sfD = 1;
    cycle(s);
    check_eq("pre_rst_busy", bus_a.mult_busy, 1'b1);
    drive(zero_stim());
    rst = 1'b0;
    #1;
    rem_a = 0; cnt_a = '0; cnt_b = '0;
    check_all();
    check_eq("rst_busy", bus_a.mult_busy, 1'b0);
    check_eq("rst_cycles", bus_a.stall_cycles, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Saturation of the 4-bit counter
    s = zero_stim();
    s.dmE = 1; s.weE = 1; s.waE = 3; s.rsD = 3;
    for (int i = 0; i < 20; i++) cycle(s);
    drive(zero_stim()); #2;
    check_eq("sat_b", bus_b.stall_cycles, 4'd15);
    check_eq("sat_a", bus_a.stall_cycles, 32'd20);
    check_all(); tick();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      s.rsD = 5'($urandom_range(0, 3)); s.rtD = 5'($urandom_range(0, 3));
      s.rsE = 5'($urandom_range(0, 3)); s.rtE = 5'($urandom_range(0, 3));
      s.waE = 5'($urandom_range(0, 3)); s.waM = 5'($urandom_range(0, 3));
      s.waW = 5'($urandom_range(0, 3));
      s.weE = 1'($urandom_range(0, 1)); s.weM = 1'($urandom_range(0, 1));
      s.weW = 1'($urandom_range(0, 1)); s.dmE = 1'($urandom_range(0, 1));
      s.dmM = 1'($urandom_range(0, 1)); s.sfM = 1'($urandom_range(0, 1));
      s.br = 1'($urandom_range(0, 1)); s.jr = ($urandom_range(0, 3) == 0);
      s.sfD = ($urandom_range(0, 3) == 0); s.meD = ($urandom_range(0, 3) == 0);
      s.meE = ($urandom_range(0, 7) == 0);
      cycle(s);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
